acc_readout: RTL and testbench

//  Sequencer that dumps the 128-bit accumulator to the host, one byte at a time.
//  - Steps the byte mux select from byte 0 to the last byte.
//  - For each byte, handshakes a one-cycle transmit pulse against the UART busy_tx.
//  - When asked, pulses the accumulator clear after the final byte.
//  - Sits between ctrl (which issues start), mux (driven by sel), uart (transmit/busy_tx) and acc (clear).

---
 rtl/acc_readout.sv | 138 +++++++++++++
 tb/tb_acc_readout.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_readout.sv
// Byte-serial dump sequencer: walks the accumulator byte select, handshakes each byte
// with the UART and optionally clears the accumulator once the last byte has gone out.
module acc_readout #(
    parameter int NBYTES      = 16,
    parameter int SEL_W       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic             clear_after,
    input  logic             uart_busy,
    output logic [SEL_W-1:0] sel,
    output logic             transmit,
    output logic             acc_clear,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FREE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        NEXT,
        CLEAR,
        DONE
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_ackCnt;
    logic             r_clrFlag;
    logic             r_transmit;
    logic             r_accClear;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Pulse outputs are set on entry to their state so each lasts exactly that state's single cycle.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_ackCnt   <= '0;
            r_clrFlag  <= 1'b0;
            r_transmit <= 1'b0;
            r_accClear <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_transmit <= 1'b0;
            r_accClear <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= WAIT_FREE;
                        r_busy    <= 1'b1;
                        r_sel     <= '0;
                        r_err     <= 1'b0;
                        r_clrFlag <= clear_after;
                    end
                end
                WAIT_FREE: begin
                    if (!uart_busy) begin
                        r_state    <= SEND;
                        r_transmit <= 1'b1;
                    end
                end
                SEND: begin
                    r_state  <= WAIT_ACK;
                    r_ackCnt <= '0;
                end
                WAIT_ACK: begin
                    if (uart_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_ackCnt == ACK_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_sel   <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_ackCnt <= r_ackCnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_sel == SEL_LAST) begin
                        if (r_clrFlag) begin
                            r_state    <= CLEAR;
                            r_accClear <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_sel   <= r_sel + SEL_W'(1);
                        r_state <= WAIT_FREE;
                    end
                end
                CLEAR: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_sel   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign transmit  = r_transmit;
    assign acc_clear = r_accClear;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_acc_readout.sv
// Scoreboard bench for acc_readout: stimulus pushes the expected transmit/clear/done
// event sequence, a negedge monitor pops and compares each event the DUT produces.
module tb_acc_readout;

    localparam int NBYTES      = 16;
    localparam int SEL_W       = 4;
    localparam int ACK_TIMEOUT = 15;
    localparam int BOUND       = 3000;

    localparam logic [7:0] EV_CLR  = 8'h20;
    localparam logic [7:0] EV_DONE = 8'h30;

    logic             clk         = 1'b0;
    logic             nRst        = 1'b0;
    logic             start       = 1'b0;
    logic             clear_after = 1'b0;
    logic             forceBusy   = 1'b0;
    logic             modelBusy   = 1'b0;
    logic             uart_busy;
    logic [SEL_W-1:0] sel;
    logic             transmit;
    logic             acc_clear;
    logic             busy;
    logic             done;
    logic             err;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         ignoreSel   = -1;
    bit         prevClr     = 1'b0;
    logic [7:0] expQ[$];

    assign uart_busy = forceBusy | modelBusy;

    always #5 clk = ~clk;

    acc_readout #(
        .NBYTES(NBYTES),
        .SEL_W(SEL_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .start(start),
        .clear_after(clear_after),
        .uart_busy(uart_busy),
        .sel(sel),
        .transmit(transmit),
        .acc_clear(acc_clear),
        .busy(busy),
        .done(done),
        .err(err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic scoreEvent(input string name, input logic [7:0] act);
        logic [7:0] exp;
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: unexpected event %0h, expected none", name, act);
        end else begin
            exp = expQ.pop_front();
            checkOutput(name, {24'h0, act}, {24'h0, exp});
        end
    endtask

    // UART model: busy rises one cycle after a transmit and stays up for 10 cycles,
    // except for the byte index in ignoreSel, which it never acknowledges.
    always begin
        @(negedge clk);
        if (transmit === 1'b1 && int'(sel) != ignoreSel) begin
            @(negedge clk);
            modelBusy = 1'b1;
            repeat (10) @(negedge clk);
            modelBusy = 1'b0;
        end
    end

    // Monitor: every output event is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (nRst) begin
            if (prevClr) checkOutput("done_after_clear", {31'h0, done}, 32'h1);
            if (transmit === 1'b1) scoreEvent("tx_event", {4'h1, sel});
            if (acc_clear === 1'b1) scoreEvent("clear_event", EV_CLR);
            if (done === 1'b1) scoreEvent("done_event", EV_DONE);
        end
        prevClr = (acc_clear === 1'b1);
    end

    task automatic pushDump(input int nTx, input bit clr, input bit finish);
        logic [3:0] s;
        for (int i = 0; i < nTx; i++) begin
            s = i[3:0];
            expQ.push_back({4'h1, s});
        end
        if (finish) begin
            if (clr) expQ.push_back(EV_CLR);
            expQ.push_back(EV_DONE);
        end
    endtask

    task automatic pulseStart(input bit clr);
        @(negedge clk);
        start       = 1'b1;
        clear_after = clr;
        @(negedge clk);
        start       = 1'b0;
        clear_after = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'h0, n < BOUND}, 32'h1);
    endtask

    task automatic waitTx(input logic [SEL_W-1:0] s, input string name);
        int n = 0;
        while (!(transmit === 1'b1 && sel == s) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'h0, n < BOUND}, 32'h1);
    endtask

    task automatic waitModelIdle();
        int n = 0;
        while (modelBusy && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput("uart_model_idle", {31'h0, n < BOUND}, 32'h1);
    endtask

    // Full dump with a free UART; start is sampled at the next rising edge,
    // so busy is up one sample later and the first transmit the sample after that.
    task automatic applyStimulus(input bit clr, input bit chkLat);
        pushDump(NBYTES, clr, 1'b1);
        pulseStart(clr);
        checkOutput("busy_after_start", {31'h0, busy}, 32'h1);
        checkOutput("err_cleared_on_start", {31'h0, err}, 32'h0);
        if (chkLat) begin
            @(negedge clk);
            checkOutput("first_tx_latency", {31'h0, transmit}, 32'h1);
        end
        waitIdle("dump_complete");
        checkOutput("queue_drained", expQ.size(), 32'h0);
        checkOutput("err_after_dump", {31'h0, err}, 32'h0);
        checkOutput("sel_after_dump", {28'h0, sel}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit sawTx;

        repeat (3) @(negedge clk);
        checkOutput("reset_sel", {28'h0, sel}, 32'h0);
        checkOutput("reset_outputs", {28'h0, transmit, acc_clear, busy, done}, 32'h0);
        checkOutput("reset_err", {31'h0, err}, 32'h0);
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] test 1: plain dump");
        applyStimulus(1'b0, 1'b1);

        $display("[TB] test 2: dump with accumulator clear");
        applyStimulus(1'b1, 1'b1);

        $display("[TB] test 3: uart busy before start");
        forceBusy = 1'b1;
        repeat (5) @(negedge clk);
        pushDump(NBYTES, 1'b0, 1'b1);
        pulseStart(1'b0);
        sawTx = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (transmit === 1'b1) sawTx = 1'b1;
        end
        checkOutput("no_tx_while_busy", {31'h0, sawTx}, 32'h0);
        forceBusy = 1'b0;
        n = 0;
        while (transmit !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx_after_busy_fall", {31'h0, n >= 1 && n <= 2}, 32'h1);
        waitIdle("dump3_complete");
        checkOutput("queue3_drained", expQ.size(), 32'h0);

        $display("[TB] test 4: ack timeout at byte 3");
        ignoreSel = 3;
        pushDump(4, 1'b0, 1'b0);
        pulseStart(1'b0);
        waitTx(4'd3, "tx_sel3_seen");
        repeat (ACK_TIMEOUT - 1) @(negedge clk);
        checkOutput("err_not_yet", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("err_on_timeout", {31'h0, err}, 32'h1);
        checkOutput("busy_after_abort", {31'h0, busy}, 32'h0);
        checkOutput("sel_after_abort", {28'h0, sel}, 32'h0);
        ignoreSel = -1;
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", {31'h0, err}, 32'h1);
        checkOutput("queue4_drained", expQ.size(), 32'h0);
        applyStimulus(1'b0, 1'b1);

        $display("[TB] test 5: start pulses during a dump");
        pushDump(NBYTES, 1'b0, 1'b1);
        pulseStart(1'b0);
        n = 0;
        while (busy === 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
            start = (busy === 1'b1 && done !== 1'b1 && (n % 3) == 0);
        end
        start = 1'b0;
        checkOutput("dump5_complete", {31'h0, n < BOUND}, 32'h1);
        repeat (5) @(negedge clk);
        checkOutput("no_second_dump", {31'h0, busy}, 32'h0);
        checkOutput("queue5_drained", expQ.size(), 32'h0);

        $display("[TB] test 6: reset in WAIT_DONE at byte 7");
        pushDump(8, 1'b0, 1'b0);
        pulseStart(1'b1);
        waitTx(4'd7, "tx_sel7_seen");
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        checkOutput("midreset_sel", {28'h0, sel}, 32'h0);
        checkOutput("midreset_outputs", {27'h0, transmit, acc_clear, busy, done, err}, 32'h0);
        checkOutput("queue6_drained", expQ.size(), 32'h0);
        waitModelIdle();
        applyStimulus(1'b0, 1'b1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
